lw_hmac_host: RTL and testbench

//  Initiator for the lw_hmac SHA/HMAC engine. Accepts one command (opcode, message length, key select), then:
//  - streams message words and, for HMAC, key words into the engine's valid/ready ports;
//  - waits for done, captures the digest and returns it word-by-word on a valid/ready output.

---
 rtl/lw_hmac_host_if.sv | 67 ++++++
 rtl/lw_hmac_host.sv | 131 +++++++++++++
 tb/tb_lw_hmac_host.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lw_hmac_host_if.sv
`default_nettype none
// ============================================================================
// Module      : lw_hmac_host_if
// Description : Command, message, key, engine and digest signals of the host.
// Revision    : 1.0  initial release
// ============================================================================
interface lw_hmac_host_if #(
  parameter int WORD_SIZE = 64,
  parameter int LEN_W     = 16
);
  logic                            cmd_valid_i;
  logic                            cmd_ready_o;
  logic [3:0]                      cmd_opcode_i;
  logic [LEN_W-1:0]                cmd_len_i;
  logic                            cmd_new_key_i;
  logic [3:0]                      cmd_dig_i;
  logic                            msg_valid_i;
  logic [WORD_SIZE-1:0]            msg_data_i;
  logic                            msg_ready_o;
  logic                            kin_valid_i;
  logic [WORD_SIZE-1:0]            kin_data_i;
  logic                            kin_ready_o;
  logic                            start_o;
  logic                            abort_o;
  logic                            last_o;
  logic                            data_valid_o;
  logic [WORD_SIZE-1:0]            data_o;
  logic [3:0]                      opcode_o;
  logic [WORD_SIZE-1:0]            key_o;
  logic                            key_valid_o;
  logic                            new_key_o;
  logic                            ready_i;
  logic                            core_ready_i;
  logic                            done_i;
  logic                            key_ready_i;
  logic [7:0][WORD_SIZE-1:0]       hash_i;
  logic                            dig_valid_o;
  logic [WORD_SIZE-1:0]            dig_data_o;
  logic                            dig_last_o;
  logic                            dig_ready_i;
  logic                            abort_i;
  logic                            busy_o;
  logic                            err_o;

  modport master (
    input  cmd_valid_i, cmd_opcode_i, cmd_len_i, cmd_new_key_i, cmd_dig_i,
    input  msg_valid_i, msg_data_i, kin_valid_i, kin_data_i,
    input  ready_i, core_ready_i, done_i, key_ready_i, hash_i,
    input  dig_ready_i, abort_i,
    output cmd_ready_o, msg_ready_o, kin_ready_o,
    output start_o, abort_o, last_o, data_valid_o, data_o,
    output opcode_o, key_o, key_valid_o, new_key_o,
    output dig_valid_o, dig_data_o, dig_last_o, busy_o, err_o
  );

  modport slave (
    output cmd_valid_i, cmd_opcode_i, cmd_len_i, cmd_new_key_i, cmd_dig_i,
    output msg_valid_i, msg_data_i, kin_valid_i, kin_data_i,
    output ready_i, core_ready_i, done_i, key_ready_i, hash_i,
    output dig_ready_i, abort_i,
    input  cmd_ready_o, msg_ready_o, kin_ready_o,
    input  start_o, abort_o, last_o, data_valid_o, data_o,
    input  opcode_o, key_o, key_valid_o, new_key_o,
    input  dig_valid_o, dig_data_o, dig_last_o, busy_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/lw_hmac_host.sv
`default_nettype none
// ============================================================================
// Module      : lw_hmac_host
// Description : Command-driven initiator for the lw_hmac engine with watchdog.
// Revision    : 1.0  initial release
// ============================================================================
module lw_hmac_host #(
  parameter int WORD_SIZE = 64,
  parameter int KEY_WORDS = 16,
  parameter int LEN_W     = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic           clk_i,
  input  logic           rst_i,
  lw_hmac_host_if.master bus
);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int KC_W = $clog2(KEY_WORDS + 1);
  localparam logic [WD_W-1:0] C_WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CORE = 3'd1,
    S_START     = 3'd2,
    S_STREAM    = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_OUTPUT    = 3'd5,
    S_ABORT     = 3'd6
  } state_t;

  state_t                    state_q;
  logic [3:0]                opcode_q;
  logic                      new_key_q;
  logic [3:0]                dig_q;
  logic [LEN_W-1:0]          len_q;
  logic [WD_W-1:0]           wd_q;
  logic [KC_W-1:0]           kcnt_q;
  logic [2:0]                didx_q;
  logic [7:0][WORD_SIZE-1:0] hash_q;
  logic                      err_q;

  logic       w_busy, w_msg_phase, w_key_xfer, w_dig_last;
  logic [2:0] w_last_idx;

  assign w_busy      = (state_q != S_IDLE);
  assign w_msg_phase = (state_q == S_START) || (state_q == S_STREAM);
  assign w_last_idx  = 3'(dig_q - 4'd1);
  assign w_dig_last  = (state_q == S_OUTPUT) && (didx_q == w_last_idx);
  assign w_key_xfer  = bus.kin_valid_i && bus.kin_ready_o;

  assign bus.cmd_ready_o  = (state_q == S_IDLE);
  assign bus.busy_o       = w_busy;
  assign bus.err_o        = err_q;
  assign bus.start_o      = (state_q == S_START) && bus.msg_valid_i;
  assign bus.data_valid_o = w_msg_phase && bus.msg_valid_i;
  assign bus.data_o       = w_msg_phase ? bus.msg_data_i : '0;
  assign bus.msg_ready_o  = (state_q == S_STREAM) && bus.ready_i;
  assign bus.last_o       = (state_q == S_STREAM) && (len_q == LEN_W'(1));
  assign bus.abort_o      = (state_q == S_ABORT);
  assign bus.opcode_o     = w_busy ? opcode_q : 4'd0;
  assign bus.new_key_o    = w_busy && new_key_q;
  // Key path is a direct pass-through; only the ready is throttled once the
  // engine has received its full key.
  assign bus.key_valid_o  = w_busy && bus.kin_valid_i;
  assign bus.key_o        = w_busy ? bus.kin_data_i : '0;
  assign bus.kin_ready_o  = w_busy && bus.key_ready_i && (kcnt_q < KC_W'(KEY_WORDS));
  assign bus.dig_valid_o  = (state_q == S_OUTPUT);
  assign bus.dig_data_o   = (state_q == S_OUTPUT) ? hash_q[didx_q] : '0;
  assign bus.dig_last_o   = w_dig_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      opcode_q  <= 4'd0;
      new_key_q <= 1'b0;
      dig_q     <= 4'd0;
      len_q     <= '0;
      wd_q      <= '0;
      kcnt_q    <= '0;
      didx_q    <= 3'd0;
      hash_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (w_busy && w_key_xfer) kcnt_q <= kcnt_q + 1'b1;
      // Software abort wins over every other event, including done_i.
      if (w_busy && bus.abort_i && state_q != S_ABORT) begin
        state_q <= S_ABORT;
      end else begin
        case (state_q)
          S_IDLE: if (bus.cmd_valid_i) begin
            opcode_q  <= bus.cmd_opcode_i;
            new_key_q <= bus.cmd_new_key_i;
            len_q     <= (bus.cmd_len_i == '0) ? LEN_W'(1) : bus.cmd_len_i;
            dig_q     <= (bus.cmd_dig_i == 4'd0) ? 4'd1 :
                         (bus.cmd_dig_i > 4'd8)  ? 4'd8 : bus.cmd_dig_i;
            err_q     <= 1'b0;
            kcnt_q    <= '0;
            wd_q      <= '0;
            didx_q    <= 3'd0;
            state_q   <= S_WAIT_CORE;
          end
          S_WAIT_CORE: if (bus.core_ready_i) state_q <= S_START;
          S_START:     if (bus.msg_valid_i) state_q <= S_STREAM;
          S_STREAM: if (bus.msg_valid_i && bus.ready_i) begin
            if (len_q == LEN_W'(1)) state_q <= S_WAIT_DONE;
            else                    len_q   <= len_q - 1'b1;
          end
          S_WAIT_DONE: begin
            if (bus.done_i) begin
              hash_q  <= bus.hash_i;
              didx_q  <= 3'd0;
              state_q <= S_OUTPUT;
            end else if (wd_q == C_WD_MAX) begin
              err_q   <= 1'b1;
              state_q <= S_ABORT;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          S_OUTPUT: if (bus.dig_ready_i) begin
            if (w_dig_last) state_q <= S_IDLE;
            else            didx_q  <= didx_q + 3'd1;
          end
          S_ABORT: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_lw_hmac_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_lw_hmac_host
// Description : Directed self-checking bench for lw_hmac_host.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lw_hmac_host;
  localparam int WS = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  lw_hmac_host_if #(.WORD_SIZE(WS), .LEN_W(16)) bus ();

  lw_hmac_host #(.WORD_SIZE(WS), .KEY_WORDS(16), .LEN_W(16), .TIMEOUT(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [15:0] len,
                          input logic nk, input logic [3:0] dig);
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_opcode_i  = op;
    bus.cmd_len_i     = len;
    bus.cmd_new_key_i = nk;
    bus.cmd_dig_i     = dig;
    tick();
    bus.cmd_valid_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: ready=%b busy=%b want 1/0", bus.cmd_ready_o, bus.busy_o);
    end
    checks++;
    if ({bus.start_o, bus.abort_o, bus.last_o, bus.data_valid_o, bus.dig_valid_o, bus.err_o,
         bus.msg_ready_o, bus.kin_ready_o} !== 8'b0) begin
      errors++; $display("FAIL reset_ctrl: start=%b abort=%b last=%b dv=%b digv=%b err=%b want 0",
                         bus.start_o, bus.abort_o, bus.last_o, bus.data_valid_o, bus.dig_valid_o, bus.err_o);
    end
  endtask

  task automatic test_sha();
    logic [WS-1:0] w;
    send_cmd(4'b0010, 16'd3, 1'b0, 4'd8);
    bus.msg_valid_i = 1'b1; bus.msg_data_i = 64'hA0; bus.ready_i = 1'b1;
    tick(); // START
    checks++;
    if (bus.start_o !== 1'b1 || bus.data_o !== 64'hA0 || bus.msg_ready_o !== 1'b0 || bus.opcode_o !== 4'b0010) begin
      errors++; $display("FAIL sha_start: start=%b data=%h mrdy=%b op=%h want 1/a0/0/2",
                         bus.start_o, bus.data_o, bus.msg_ready_o, bus.opcode_o);
    end
    tick(); // STREAM
    checks++;
    if (bus.start_o !== 1'b0) begin
      errors++; $display("FAIL sha_start_width: start=%b want 0", bus.start_o);
    end
    for (int i = 0; i < 3; i++) begin
      w = 64'hB0 + 64'(i);
      bus.msg_data_i = w;
      #1;
      checks++;
      if (bus.msg_ready_o !== 1'b1 || bus.last_o !== (i == 2) || bus.data_o !== w) begin
        errors++; $display("FAIL sha_stream%0d: mrdy=%b last=%b data=%h want 1/%0d/%h",
                           i, bus.msg_ready_o, bus.last_o, bus.data_o, (i == 2), w);
      end
      tick();
    end
    bus.msg_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.msg_ready_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.dig_valid_o !== 1'b0) begin
      errors++; $display("FAIL sha_wait: mrdy=%b busy=%b digv=%b want 0/1/0", bus.msg_ready_o, bus.busy_o, bus.dig_valid_o);
    end
    for (int k = 0; k < 8; k++) bus.hash_i[k] = 64'(k);
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0;
    for (int k = 0; k < 8; k++) bus.hash_i[k] = 64'hDEAD;
    bus.dig_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (bus.dig_valid_o !== 1'b1 || bus.dig_data_o !== 64'(k) || bus.dig_last_o !== (k == 7)) begin
        errors++; $display("FAIL sha_dig%0d: v=%b data=%h last=%b want 1/%h/%0d",
                           k, bus.dig_valid_o, bus.dig_data_o, bus.dig_last_o, 64'(k), (k == 7));
      end
      tick();
    end
    checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.dig_valid_o !== 1'b0) begin
      errors++; $display("FAIL sha_idle: ready=%b digv=%b want 1/0", bus.cmd_ready_o, bus.dig_valid_o);
    end
  endtask

  task automatic test_hmac();
    int nx = 0;
    logic [WS-1:0] k;
    bus.core_ready_i = 1'b0;
    send_cmd(4'b0011, 16'd1, 1'b1, 4'd4);
    checks++;
    if (bus.new_key_o !== 1'b1 || bus.opcode_o !== 4'b0011) begin
      errors++; $display("FAIL hmac_hold: new_key=%b op=%h want 1/3", bus.new_key_o, bus.opcode_o);
    end
    bus.kin_valid_i = 1'b1; bus.key_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      k = 64'hC000 + 64'(i);
      bus.kin_data_i = k;
      #1;
      checks++;
      if (bus.kin_ready_o !== (i < 16) || bus.key_valid_o !== 1'b1 || bus.key_o !== k) begin
        errors++; $display("FAIL hmac_key%0d: krdy=%b kv=%b key=%h want %0d/1/%h",
                           i, bus.kin_ready_o, bus.key_valid_o, bus.key_o, (i < 16), k);
      end
      if (bus.kin_valid_i && bus.kin_ready_o) nx++;
      tick();
    end
    checks++;
    if (nx !== 16) begin
      errors++; $display("FAIL hmac_key_count: got %0d want 16", nx);
    end
    bus.kin_valid_i = 1'b0; bus.key_ready_i = 1'b0;
    bus.core_ready_i = 1'b1; bus.msg_valid_i = 1'b1; bus.msg_data_i = 64'hD0; bus.ready_i = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if (bus.last_o !== 1'b1 || bus.msg_ready_o !== 1'b1) begin
      errors++; $display("FAIL hmac_last: last=%b mrdy=%b want 1/1", bus.last_o, bus.msg_ready_o);
    end
    tick();
    bus.msg_valid_i = 1'b0;
    for (int j = 0; j < 8; j++) bus.hash_i[j] = 64'h100 + 64'(j);
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0; bus.dig_ready_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++;
      if (bus.dig_valid_o !== 1'b1 || bus.dig_data_o !== 64'h100 + 64'(j) || bus.dig_last_o !== (j == 3)) begin
        errors++; $display("FAIL hmac_dig%0d: v=%b data=%h last=%b want 1/%h/%0d",
                           j, bus.dig_valid_o, bus.dig_data_o, bus.dig_last_o, 64'h100 + 64'(j), (j == 3));
      end
      tick();
    end
    checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.new_key_o !== 1'b0) begin
      errors++; $display("FAIL hmac_idle: ready=%b new_key=%b want 1/0", bus.cmd_ready_o, bus.new_key_o);
    end
  endtask

  task automatic test_backpressure();
    int j = 0;
    logic [WS-1:0] w;
    send_cmd(4'b0010, 16'd4, 1'b0, 4'd2);
    bus.msg_valid_i = 1'b1; bus.msg_data_i = 64'hE0;
    tick(); tick(); // through START into STREAM
    for (int c = 0; c < 20 && j < 4; c++) begin
      w = 64'hE0 + 64'(j);
      bus.msg_data_i = w;
      bus.ready_i = c[0];
      #1;
      checks++;
      if (bus.data_o !== w || bus.msg_ready_o !== c[0] || bus.last_o !== (j == 3)) begin
        errors++; $display("FAIL bp_stream c%0d: data=%h mrdy=%b last=%b want %h/%b/%0d",
                           c, bus.data_o, bus.msg_ready_o, bus.last_o, w, c[0], (j == 3));
      end
      if (bus.msg_ready_o) j++;
      tick();
    end
    bus.msg_valid_i = 1'b0; bus.ready_i = 1'b1;
    checks++;
    if (j !== 4 || bus.msg_ready_o !== 1'b0) begin
      errors++; $display("FAIL bp_count: transfers=%0d mrdy=%b want 4/0", j, bus.msg_ready_o);
    end
    for (int k = 0; k < 8; k++) bus.hash_i[k] = 64'h200 + 64'(k);
    bus.done_i = 1'b1; bus.dig_ready_i = 1'b0;
    tick();
    bus.done_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.dig_valid_o !== 1'b1 || bus.dig_data_o !== 64'h200 || bus.dig_last_o !== 1'b0) begin
        errors++; $display("FAIL bp_stall%0d: v=%b data=%h last=%b want 1/200/0",
                           c, bus.dig_valid_o, bus.dig_data_o, bus.dig_last_o);
      end
      tick();
    end
    bus.dig_ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (bus.dig_data_o !== 64'h200 + 64'(k) || bus.dig_last_o !== (k == 1)) begin
        errors++; $display("FAIL bp_dig%0d: data=%h last=%b want %h/%0d",
                           k, bus.dig_data_o, bus.dig_last_o, 64'h200 + 64'(k), (k == 1));
      end
      tick();
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL bp_idle: busy=%b want 0", bus.busy_o);
    end
  endtask

  task automatic test_watchdog();
    int n = -1;
    send_cmd(4'b0010, 16'd1, 1'b0, 4'd1);
    bus.msg_valid_i = 1'b1; bus.ready_i = 1'b1;
    tick(); tick(); tick(); // START, STREAM, transfer -> WAIT_DONE
    bus.msg_valid_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.abort_o) begin n = c; break; end
      tick();
    end
    checks++;
    if (n !== 16 || bus.err_o !== 1'b1 || bus.dig_valid_o !== 1'b0) begin
      errors++; $display("FAIL wd_timeout: abort_at=%0d err=%b digv=%b want 16/1/0", n, bus.err_o, bus.dig_valid_o);
    end
    tick();
    checks++;
    if (bus.abort_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 || bus.err_o !== 1'b1) begin
      errors++; $display("FAIL wd_after: abort=%b ready=%b err=%b want 0/1/1", bus.abort_o, bus.cmd_ready_o, bus.err_o);
    end
    bus.core_ready_i = 1'b0;
    send_cmd(4'b0010, 16'd1, 1'b0, 4'd1);
    checks++;
    if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++; $display("FAIL wd_clear: err=%b busy=%b want 0/1", bus.err_o, bus.busy_o);
    end
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    bus.core_ready_i = 1'b1;
    checks++;
    if (bus.abort_o !== 1'b1 || bus.err_o !== 1'b0) begin
      errors++; $display("FAIL wd_sw_abort: abort=%b err=%b want 1/0", bus.abort_o, bus.err_o);
    end
    tick();
  endtask

  task automatic test_abort_done();
    send_cmd(4'b0010, 16'd1, 1'b0, 4'd8);
    bus.msg_valid_i = 1'b1; bus.ready_i = 1'b1;
    tick(); tick(); tick();
    bus.msg_valid_i = 1'b0;
    bus.done_i = 1'b1; bus.abort_i = 1'b1;
    tick();
    bus.done_i = 1'b0; bus.abort_i = 1'b0;
    checks++;
    if (bus.abort_o !== 1'b1 || bus.dig_valid_o !== 1'b0) begin
      errors++; $display("FAIL abort_done: abort=%b digv=%b want 1/0", bus.abort_o, bus.dig_valid_o);
    end
    tick();
    checks++;
    if (bus.abort_o !== 1'b0 || bus.dig_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL abort_idle: abort=%b digv=%b ready=%b want 0/0/1",
                         bus.abort_o, bus.dig_valid_o, bus.cmd_ready_o);
    end
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    checks++;
    if (bus.abort_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL abort_in_idle: abort=%b ready=%b want 0/1", bus.abort_o, bus.cmd_ready_o);
    end
  endtask

  task automatic test_reset_stream();
    send_cmd(4'b0011, 16'd5, 1'b1, 4'd8);
    bus.msg_valid_i = 1'b1; bus.ready_i = 1'b1; bus.kin_valid_i = 1'b1; bus.key_ready_i = 1'b1;
    tick(); tick(); tick(); // one word into STREAM
    checks++;
    if (bus.msg_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_pre: mrdy=%b want 1", bus.msg_ready_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 ||
        {bus.start_o, bus.abort_o, bus.last_o, bus.data_valid_o, bus.msg_ready_o,
         bus.key_valid_o, bus.kin_ready_o, bus.new_key_o} !== 8'b0 || bus.opcode_o !== 4'd0) begin
      errors++; $display("FAIL rst_stream: busy=%b ready=%b ctl=%b%b%b%b%b%b%b%b op=%h want 0/1/0/0",
                         bus.busy_o, bus.cmd_ready_o, bus.start_o, bus.abort_o, bus.last_o,
                         bus.data_valid_o, bus.msg_ready_o, bus.key_valid_o, bus.kin_ready_o,
                         bus.new_key_o, bus.opcode_o);
    end
    bus.msg_valid_i = 1'b0; bus.kin_valid_i = 1'b0; bus.key_ready_i = 1'b0;
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_opcode_i = 4'd0; bus.cmd_len_i = '0;
    bus.cmd_new_key_i = 1'b0; bus.cmd_dig_i = 4'd0;
    bus.msg_valid_i = 1'b0; bus.msg_data_i = '0;
    bus.kin_valid_i = 1'b0; bus.kin_data_i = '0;
    bus.ready_i = 1'b0; bus.core_ready_i = 1'b1; bus.done_i = 1'b0; bus.key_ready_i = 1'b0;
    bus.hash_i = '0; bus.dig_ready_i = 1'b0; bus.abort_i = 1'b0;
    test_reset();
    test_sha();
    test_hmac();
    test_backpressure();
    test_watchdog();
    test_abort_done();
    test_reset_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
